// File: rtl/servo_pkg.sv
// Shared servo-path types: position width, position type and slew FSM states.
package servo_pkg;

  localparam int unsigned POS_W = 12;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    PAUSE = 2'd2
  } slew_state_t;

endpackage : servo_pkg

// File: rtl/slew_tick.sv
// Ramp tick divider: counts 0..TICK_DIV-1 while enabled, flags the terminal count.
// o_tc_c is combinational (counter at terminal value); the caller gates it with its enable.
module slew_tick
  import servo_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Divider counter: clear has priority, wraps to zero after the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == TC_VAL) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_tc_c = (r_cnt == TC_VAL);

endmodule : slew_tick

// File: rtl/setpoint_slew.sv
// Setpoint slew-rate limiter between the position converter and the PID setpoint.
// Moves the setpoint toward the latched target by at most STEP every TICK_DIV cycles;
// the ramp freezes while hold (overcurrent) is high.
// Optional build macro SETPOINT_LIMIT_EN: clamp targets and INIT_POS to [POS_MIN, POS_MAX].
module setpoint_slew
  import servo_pkg::*;
#(
  parameter int unsigned WIDTH    = POS_W,
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned STEP     = 4,
  parameter int unsigned INIT_POS = 2048,
  parameter int unsigned POS_MIN  = 0,
  parameter int unsigned POS_MAX  = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] target_in,
  input  logic             target_valid,
  input  logic             hold,
  output logic [WIDTH-1:0] setpoint_out,
  output logic             ramping,
  output logic             at_target
);

  // Reject parameter sets the datapath cannot honour.
  if (TICK_DIV < 2 || STEP < 1 || POS_MIN > POS_MAX) begin : g_bad_params
    $error("setpoint_slew: invalid TICK_DIV/STEP/POS_MIN/POS_MAX");
  end

`ifdef SETPOINT_LIMIT_EN
  localparam int unsigned INIT_CLAMP = (INIT_POS < POS_MIN) ? POS_MIN :
                                       (INIT_POS > POS_MAX) ? POS_MAX : INIT_POS;
`else
  localparam int unsigned INIT_CLAMP = INIT_POS;
`endif
  localparam logic [WIDTH-1:0] INIT_EFF = WIDTH'(INIT_CLAMP);
  localparam logic [WIDTH:0]   STEP_D   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

  slew_state_t              r_state;
  slew_state_t              w_state_nxt;
  logic        [WIDTH-1:0]  r_setpoint;
  logic        [WIDTH-1:0]  r_target;
  logic                     r_ramping;
  logic                     r_at_target;
  logic        [WIDTH-1:0]  w_target_lim;
  logic        [WIDTH-1:0]  w_step_val;
  logic signed [WIDTH:0]    w_diff;
  logic        [WIDTH:0]    w_mag;
  logic                     w_ne;
  logic                     w_close;
  logic                     w_do_step;
  logic                     w_tick_clr;
  logic                     w_tick_en;
  logic                     w_tc;

  slew_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_tick_clr),
    .i_en   (w_tick_en),
    .o_tc_c (w_tc)
  );

  // Optional clamp on the incoming target before it is latched.
  always_comb begin
`ifdef SETPOINT_LIMIT_EN
    if (target_in < WIDTH'(POS_MIN)) begin
      w_target_lim = WIDTH'(POS_MIN);
    end else if (target_in > WIDTH'(POS_MAX)) begin
      w_target_lim = WIDTH'(POS_MAX);
    end else begin
      w_target_lim = target_in;
    end
`else
    w_target_lim = target_in;
`endif
  end

  // Signed distance to target in WIDTH+1 bits, its magnitude, and the next step value.
  always_comb begin
    w_diff     = $signed({1'b0, r_target}) - $signed({1'b0, r_setpoint});
    w_mag      = w_diff[WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
    w_ne       = (r_target != r_setpoint);
    w_close    = (w_mag <= STEP_D);
    w_step_val = r_setpoint;
    if (w_close) begin
      w_step_val = r_target;
    end else if (w_diff[WIDTH]) begin
      w_step_val = r_setpoint - STEP_W;
    end else begin
      w_step_val = r_setpoint + STEP_W;
    end
  end

  // Next-state and tick control; hold always dominates a pending step.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_clr  = 1'b0;
    w_tick_en   = 1'b0;
    w_do_step   = 1'b0;
    case (r_state)
      IDLE: begin
        w_tick_clr = 1'b1;
        if (w_ne) begin
          if (hold) begin
            w_state_nxt = PAUSE;
          end else begin
            w_state_nxt = RAMP;
            w_tick_clr  = 1'b0;
            w_tick_en   = 1'b1;
          end
        end
      end
      RAMP: begin
        if (hold) begin
          w_state_nxt = PAUSE;
        end else if (!w_ne) begin
          w_state_nxt = IDLE;
        end else begin
          w_tick_en = 1'b1;
          if (w_tc) begin
            w_do_step = 1'b1;
            if (w_close) begin
              w_state_nxt = IDLE;
            end
          end
        end
      end
      PAUSE: begin
        if (!hold) begin
          w_state_nxt = RAMP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Target latch, setpoint step and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target    <= INIT_EFF;
      r_setpoint  <= INIT_EFF;
      r_ramping   <= 1'b0;
      r_at_target <= 1'b1;
    end else begin
      if (target_valid) begin
        r_target <= w_target_lim;
      end
      if (w_do_step) begin
        r_setpoint <= w_step_val;
      end
      r_ramping   <= (w_state_nxt != IDLE);
      r_at_target <= (w_state_nxt == IDLE);
    end
  end

  assign setpoint_out = r_setpoint;
  assign ramping      = r_ramping;
  assign at_target    = r_at_target;

endmodule : setpoint_slew

// File: tb/tb_setpoint_slew.sv
// Self-checking bench for setpoint_slew (TICK_DIV=4, STEP=4, INIT_POS=2048).
// Expected setpoint changes are queued with the stimulus and matched against
// observed changes recorded on falling edges.
module tb_setpoint_slew;

`ifdef SETPOINT_LIMIT_EN
  localparam int unsigned LIM_MAX = 3000;
`else
  localparam int unsigned LIM_MAX = 4095;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] target_in = 12'd0;
  logic        target_valid = 1'b0;
  logic        hold = 1'b0;
  logic [11:0] setpoint_out;
  logic        ramping;
  logic        at_target;

  setpoint_slew #(
    .WIDTH    (12),
    .TICK_DIV (4),
    .STEP     (4),
    .INIT_POS (2048),
    .POS_MIN  (0),
    .POS_MAX  (LIM_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .target_in    (target_in),
    .target_valid (target_valid),
    .hold         (hold),
    .setpoint_out (setpoint_out),
    .ramping      (ramping),
    .at_target    (at_target)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          t0      = 0;
  logic [11:0] prev_sp = 12'd2048;
  logic [11:0] exp_q[$];
  int          exp_t[$];
  logic [11:0] obs_v[$];
  int          obs_t[$];

  // Advance to the next falling edge and record any setpoint change.
  task automatic tick();
    @(negedge clk);
    if (setpoint_out !== prev_sp) begin
      obs_v.push_back(setpoint_out);
      obs_t.push_back(cyc - t0);
      prev_sp = setpoint_out;
    end
  endtask

  task automatic clear_sb();
    exp_q.delete(); exp_t.delete(); obs_v.delete(); obs_t.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; hold = 1'b0; target_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    prev_sp = setpoint_out;
    clear_sb();
  endtask

  // Present v for one cycle; t0 marks the edge that latched it (edge 0).
  task automatic apply_target(input logic [11:0] v);
    tick();
    target_in = v; target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (setpoint_out !== 12'd2048) begin n_fail++; $display("FAIL reset_setpoint got %0d want 2048", setpoint_out); end
    n_tests++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL reset_at_target got %b want 1", at_target); end
    n_tests++; if (ramping !== 1'b0) begin n_fail++; $display("FAIL reset_ramping got %b want 0", ramping); end
  endtask

  task automatic test_ramp_up();
    logic [11:0] ev, ov; int et, ot;
    do_reset();
    exp_q = '{12'd2052, 12'd2056, 12'd2060}; exp_t = '{4, 8, 12};
    apply_target(12'd2060);
    tick();
    n_tests++; if (ramping !== 1'b1 || at_target !== 1'b0) begin n_fail++; $display("FAIL ramp_up_flags_edge1 got ramping=%b at_target=%b want 1/0", ramping, at_target); end
    repeat (13) tick();
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front(); et = exp_t.pop_front(); n_tests++;
      if (obs_v.size() == 0) begin n_fail++; $display("FAIL ramp_up_step got none want %0d at edge %0d", ev, et); end
      else begin
        ov = obs_v.pop_front(); ot = obs_t.pop_front();
        if (ov !== ev || ot !== et) begin n_fail++; $display("FAIL ramp_up_step got %0d at edge %0d want %0d at edge %0d", ov, ot, ev, et); end
      end
    end
    n_tests++; if (obs_v.size() != 0) begin n_fail++; $display("FAIL ramp_up_extra got %0d extra changes want 0", obs_v.size()); end
    n_tests++; if (at_target !== 1'b1 || ramping !== 1'b0) begin n_fail++; $display("FAIL ramp_up_done got at_target=%b ramping=%b want 1/0", at_target, ramping); end
  endtask

  task automatic test_small_step();
    logic [11:0] ev, ov; int et, ot;
    do_reset();
    exp_q.push_back(12'd2046); exp_t.push_back(4);
    apply_target(12'd2046);
    repeat (7) tick();
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front(); et = exp_t.pop_front(); n_tests++;
      if (obs_v.size() == 0) begin n_fail++; $display("FAIL small_step got none want %0d at edge %0d", ev, et); end
      else begin
        ov = obs_v.pop_front(); ot = obs_t.pop_front();
        if (ov !== ev || ot !== et) begin n_fail++; $display("FAIL small_step got %0d at edge %0d want %0d at edge %0d", ov, ot, ev, et); end
      end
    end
    n_tests++; if (obs_v.size() != 0 || at_target !== 1'b1) begin n_fail++; $display("FAIL small_step_done got extra=%0d at_target=%b want 0/1", obs_v.size(), at_target); end
  endtask

  task automatic test_hold();
    bit moved;
    do_reset();
    apply_target(12'd2100);
    for (int i = 0; i < 20 && obs_v.size() < 1; i++) tick();
    n_tests++; if (obs_v.size() < 1 || obs_v[0] !== 12'd2052 || obs_t[0] != 4) begin n_fail++; $display("FAIL hold_first_step got n=%0d want 2052 at edge 4", obs_v.size()); end
    hold = 1'b1;
    moved = 1'b0;
    repeat (10) begin tick(); if (setpoint_out !== 12'd2052) moved = 1'b1; end
    n_tests++; if (moved) begin n_fail++; $display("FAIL hold_frozen got %0d want 2052", setpoint_out); end
    n_tests++; if (ramping !== 1'b1 || at_target !== 1'b0) begin n_fail++; $display("FAIL hold_pause_flags got ramping=%b at_target=%b want 1/0", ramping, at_target); end
    hold = 1'b0;
    for (int i = 0; i < 10 && obs_v.size() < 2; i++) tick();
    n_tests++;
    if (obs_v.size() < 2) begin n_fail++; $display("FAIL hold_resume got no step want 2056 by edge 19"); end
    else if (obs_v[1] !== 12'd2056 || obs_t[1] < 18 || obs_t[1] > 19) begin
      n_fail++; $display("FAIL hold_resume got %0d at edge %0d want 2056 at edge 18..19", obs_v[1], obs_t[1]);
    end
  endtask

  task automatic test_hold_idle();
    do_reset();
    hold = 1'b1;
    apply_target(12'd2060);
    repeat (4) tick();
    n_tests++; if (ramping !== 1'b1 || at_target !== 1'b0 || setpoint_out !== 12'd2048) begin n_fail++; $display("FAIL hold_idle got ramping=%b at_target=%b sp=%0d want 1/0/2048", ramping, at_target, setpoint_out); end
    hold = 1'b0;
    for (int i = 0; i < 40 && at_target !== 1'b1; i++) tick();
    n_tests++; if (at_target !== 1'b1 || setpoint_out !== 12'd2060) begin n_fail++; $display("FAIL hold_idle_release got at_target=%b sp=%0d want 1/2060", at_target, setpoint_out); end
  endtask

  task automatic test_retarget();
    logic [11:0] ev, ov; int et, ot;
    do_reset();
    apply_target(12'd2100);
    for (int i = 0; i < 20 && obs_v.size() < 2; i++) tick();
    n_tests++; if (obs_v.size() < 2 || obs_v[1] !== 12'd2056 || obs_t[1] != 8) begin n_fail++; $display("FAIL retarget_pre got n=%0d want 2056 at edge 8", obs_v.size()); end
    clear_sb();
    exp_q = '{12'd2052, 12'd2048, 12'd2044, 12'd2040}; exp_t = '{2, 6, 10, 14};
    apply_target(12'd2040);
    repeat (16) tick();
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front(); et = exp_t.pop_front(); n_tests++;
      if (obs_v.size() == 0) begin n_fail++; $display("FAIL retarget_step got none want %0d at +%0d", ev, et); end
      else begin
        ov = obs_v.pop_front(); ot = obs_t.pop_front();
        if (ov !== ev || ot !== et) begin n_fail++; $display("FAIL retarget_step got %0d at +%0d want %0d at +%0d", ov, ot, ev, et); end
      end
    end
    n_tests++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL retarget_done got at_target=%b want 1", at_target); end
  endtask

  task automatic test_limits();
    bit bad;
    int pen;
    do_reset();
    apply_target(12'd4095);
    tick();
    for (int i = 0; i < 3000 && at_target !== 1'b1; i++) tick();
    n_tests++; if (at_target !== 1'b1 || setpoint_out !== 12'(LIM_MAX)) begin n_fail++; $display("FAIL limit_top got sp=%0d at_target=%b want %0d/1", setpoint_out, at_target, LIM_MAX); end
    clear_sb();
    apply_target(12'd0);
    tick();
    for (int i = 0; i < 5000 && at_target !== 1'b1; i++) tick();
    n_tests++; if (at_target !== 1'b1 || setpoint_out !== 12'd0) begin n_fail++; $display("FAIL limit_bottom got sp=%0d at_target=%b want 0/1", setpoint_out, at_target); end
    bad = (obs_v.size() < 2);
    for (int i = 1; i < obs_v.size(); i++)
      if (obs_v[i] >= obs_v[i-1] || (obs_v[i-1] - obs_v[i]) > 12'd4) bad = 1'b1;
    n_tests++; if (bad) begin n_fail++; $display("FAIL limit_descent got non-monotonic or oversized step, n=%0d want steps of 1..4 down", obs_v.size()); end
    pen = (LIM_MAX % 4 == 0) ? 4 : int'(LIM_MAX % 4);
    n_tests++; if (obs_v.size() < 2 || int'(obs_v[obs_v.size()-2]) != pen) begin n_fail++; $display("FAIL limit_last_step got n=%0d want penultimate %0d", obs_v.size(), pen); end
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    apply_target(12'd2100);
    repeat (6) tick();
    n_tests++; if (setpoint_out !== 12'd2052 || ramping !== 1'b1) begin n_fail++; $display("FAIL midreset_pre got sp=%0d ramping=%b want 2052/1", setpoint_out, ramping); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (setpoint_out !== 12'd2048 || at_target !== 1'b1 || ramping !== 1'b0) begin n_fail++; $display("FAIL midreset_async got sp=%0d at_target=%b ramping=%b want 2048/1/0", setpoint_out, at_target, ramping); end
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    n_tests++; if (setpoint_out !== 12'd2048 || at_target !== 1'b1) begin n_fail++; $display("FAIL midreset_after got sp=%0d at_target=%b want 2048/1", setpoint_out, at_target); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_small_step();
    test_hold();
    test_hold_idle();
    test_retarget();
    test_limits();
    test_reset_mid_ramp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_setpoint_slew
